// File: rtl/mem_pkg.sv
// Shared definitions for the memory interface: FSM state encoding and default geometry.
package mem_pkg;

    localparam int MEM_ADDR_W_DEF      = 9;
    localparam int MEM_WAIT_CYCLES_DEF = 1;
    localparam int MEM_CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_interface.sv
// MAR/MDR to synchronous-RAM access sequencer with a programmable wait count.
// Optional MEM_RANGE_CHECK_EN flags requests whose MAR exceeds the RAM address range.
//
// state   | meaning
// IDLE    | waiting for Read/Write; MAR loads freely
// ACCESS  | one cycle with ram_re or ram_we asserted
// WAIT    | counting down RAM latency; read data captured on the last edge
// DONE    | one-cycle mem_done (and mem_err) pulse
module mem_interface
    import mem_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W_DEF,
    parameter int WAIT_CYCLES = MEM_WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              MARin,
    input  logic [31:0]       BusMuxOut,
    input  logic [31:0]       mdr_q,
    input  logic              Read,
    input  logic              Write,
    output logic [31:0]       Mdatain,
    output logic              busy,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_re,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    output logic              mem_err
);

    localparam logic [MEM_CNT_W-1:0] WAIT_INIT = MEM_CNT_W'(WAIT_CYCLES - 1);

    mem_state_t           state, state_nxt;
    logic [MEM_CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]          mar;
    logic                 op_rd;
    logic                 start;
    logic                 capture;

`ifdef MEM_RANGE_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!clr) begin
            err_q <= 1'b0;
        end else if (start) begin
            err_q <= |mar[31:ADDR_W];
        end
    end

    assign mem_err = (state == ST_DONE) && err_q;
`else
    logic err_q;
    logic unused_mar_hi;

    // Upper MAR bits are deliberately dropped: the address wraps.
    assign err_q         = 1'b0;
    assign unused_mar_hi = ^mar[31:ADDR_W];
    assign mem_err       = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start     = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Read || Write) begin
                    state_nxt = ST_ACCESS;
                    start     = 1'b1;
                end
            end
            ST_ACCESS: begin
                state_nxt = ST_WAIT;
                cnt_nxt   = WAIT_INIT;
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_DONE;
                    capture   = op_rd && !err_q;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state != ST_IDLE);
    assign mem_done = (state == ST_DONE);
    assign ram_re   = (state == ST_ACCESS) && op_rd && !err_q;
    assign ram_we   = (state == ST_ACCESS) && !op_rd && !err_q;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mar       <= '0;
            op_rd     <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            Mdatain   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (MARin) begin
                mar <= BusMuxOut;
            end
            // Read wins when both requests arrive together.
            if (start) begin
                ram_addr  <= mar[ADDR_W-1:0];
                ram_wdata <= mdr_q;
                op_rd     <= Read;
            end
            if (capture) begin
                Mdatain <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_interface.sv
// Scoreboard bench for mem_interface: expected transactions queued at request time, checked at mem_done.
module tb_mem_interface;

    localparam int ADDR_W = 9;
`ifdef MEM_RANGE_CHECK_EN
    localparam int WC = 4;
`else
    localparam int WC = 1;
`endif

    logic              clk;
    logic              clr;
    logic              MARin;
    logic [31:0]       BusMuxOut;
    logic [31:0]       mdr_q;
    logic              Read;
    logic              Write;
    logic [31:0]       Mdatain;
    logic              busy;
    logic              mem_done;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_re;
    logic              ram_we;
    logic [31:0]       ram_rdata;
    logic              mem_err;

    mem_interface #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WC)) dut (
        .clk       (clk),
        .clr       (clr),
        .MARin     (MARin),
        .BusMuxOut (BusMuxOut),
        .mdr_q     (mdr_q),
        .Read      (Read),
        .Write     (Write),
        .Mdatain   (Mdatain),
        .busy      (busy),
        .mem_done  (mem_done),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_re    (ram_re),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .mem_err   (mem_err)
    );

    typedef struct {
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [31:0]       mdat;
        logic              err;
        int                t0;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          re_cnt = 0;
    int          we_cnt = 0;
    logic [31:0] ram     [0:511];
    logic [31:0] ref_mem [0:511];
    logic [31:0] ref_mdat;
    logic [31:0] cur_mar;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic range_err(input logic [31:0] m);
`ifdef MEM_RANGE_CHECK_EN
        return |m[31:ADDR_W];
`else
        return 1'b0;
`endif
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: read data valid the cycle after ram_re.
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= ram[ram_addr];
    end

    always @(negedge clk) begin : monitor
        exp_t it;
        if (ram_re || ram_we) begin
            chk("strobe_excl", 32'(ram_re & ram_we), 32'd0);
            if (sb_q.size() > 0) begin
                chk("strobe_addr", 32'(ram_addr), 32'(sb_q[0].addr));
                if (ram_we) chk("strobe_wdata", ram_wdata, sb_q[0].wdata);
            end else begin
                chk("strobe_no_req", {30'd0, ram_re, ram_we}, 32'd0);
            end
        end
        if (ram_re) re_cnt++;
        if (ram_we) we_cnt++;
        if (mem_done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'(mem_done), 32'd0);
            end else begin
                it = sb_q.pop_front();
                chk("latency", 32'(cyc - it.t0), 32'(2 + WC));
                chk("re_count", 32'(re_cnt), 32'(it.rd && !it.err));
                chk("we_count", 32'(we_cnt), 32'(!it.rd && !it.err));
                chk("mdatain", Mdatain, it.mdat);
                chk("addr_held", 32'(ram_addr), 32'(it.addr));
                chk("mem_err", 32'(mem_err), 32'(it.err));
            end
            done_cnt++;
        end
    end

    task automatic push_req(input logic rd, input logic [31:0] wd);
        exp_t it;
        it.rd    = rd;
        it.addr  = cur_mar[ADDR_W-1:0];
        it.wdata = wd;
        it.err   = range_err(cur_mar);
        if (!it.err) begin
            if (rd) ref_mdat = ref_mem[it.addr];
            else    ref_mem[it.addr] = wd;
        end
        it.mdat = ref_mdat;
        it.t0   = cyc;
        re_cnt  = 0;
        we_cnt  = 0;
        sb_q.push_back(it);
    endtask

    task automatic load_mar(input logic [31:0] v);
        @(negedge clk);
        MARin     = 1'b1;
        BusMuxOut = v;
        cur_mar   = v;
        @(negedge clk);
        MARin = 1'b0;
    endtask

    task automatic wait_done(input int start);
        for (int i = 0; i < 40 && done_cnt == start; i++) @(negedge clk);
        chk("done_seen", 32'(done_cnt), 32'(start + 1));
        @(negedge clk);
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] wd);
        int start;
        start = done_cnt;
        mdr_q = wd;
        Read  = rd;
        Write = wr;
        push_req(rd, wd);
        @(negedge clk);
        Read  = 1'b0;
        Write = 1'b0;
        mdr_q = ~wd;
        wait_done(start);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int start;
        logic [31:0] a, d;
        for (int i = 0; i < 512; i++) begin
            ram[i]     = 32'hA5A5_0000 ^ 32'(i);
            ref_mem[i] = 32'hA5A5_0000 ^ 32'(i);
        end
        clr = 1'b0; MARin = 1'b0; BusMuxOut = '0; mdr_q = '0;
        Read = 1'b0; Write = 1'b0; ref_mdat = '0; cur_mar = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(mem_done), 32'd0);
        chk("rst_strobes", {30'd0, ram_re, ram_we}, 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_wdata", ram_wdata, 32'd0);
        chk("rst_mdatain", Mdatain, 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        clr = 1'b1;
        @(negedge clk);

        // Write then read back 0x012; Mdatain must survive a later write.
        load_mar(32'h0000_0012);
        do_req(1'b0, 1'b1, 32'hDEAD_BEEF);
        do_req(1'b1, 1'b0, 32'h0);
        load_mar(32'h0000_0034);
        do_req(1'b0, 1'b1, 32'h1234_5678);

        // Simultaneous Read and Write behaves as a read.
        do_req(1'b1, 1'b1, 32'h5555_AAAA);

        // New request and MAR load during WAIT: ignored by the FSM, MAR still loads.
        load_mar(32'h0000_0012);
        start = done_cnt;
        Read  = 1'b1;
        push_req(1'b1, 32'h0);
        @(negedge clk);
        Read = 1'b0;
        @(negedge clk);
        Read = 1'b1; MARin = 1'b1; BusMuxOut = 32'h0000_01FF;
        @(negedge clk);
        Read = 1'b0; MARin = 1'b0; cur_mar = 32'h0000_01FF;
        wait_done(start);
        repeat (4) @(negedge clk);
        chk("single_done", 32'(done_cnt), 32'(start + 1));
        chk("idle_after", 32'(busy), 32'd0);
        do_req(1'b1, 1'b0, 32'h0);

        // Reset during WAIT aborts the access.
        load_mar(32'h0000_0034);
        start = done_cnt;
        Read  = 1'b1;
        push_req(1'b1, 32'h0);
        @(negedge clk);
        Read = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(mem_done), 32'd0);
        chk("abort_strobes", {30'd0, ram_re, ram_we}, 32'd0);
        chk("abort_addr", 32'(ram_addr), 32'd0);
        chk("abort_wdata", ram_wdata, 32'd0);
        chk("abort_mdatain", Mdatain, 32'd0);
        clr = 1'b1;
        sb_q.delete();
        ref_mdat = '0;
        cur_mar  = '0;
        @(negedge clk);
        chk("abort_no_strobe", {30'd0, ram_re, ram_we}, 32'd0);
        chk("abort_no_pulse", 32'(done_cnt), 32'(start));

        // Out-of-range MAR: wraps by default, flagged when range checking is built in.
        load_mar(32'h0000_0200);
        do_req(1'b1, 1'b0, 32'h0);
        load_mar(32'h0000_0212);
        do_req(1'b0, 1'b1, 32'hCAFE_F00D);
        load_mar(32'h0000_0012);
        do_req(1'b1, 1'b0, 32'h0);

        for (int i = 0; i < 6; i++) begin
            a = 32'($urandom_range(0, 511));
            d = $urandom;
            load_mar(a);
            do_req(1'b0, 1'b1, d);
            load_mar(a);
            do_req(1'b1, 1'b0, 32'h0);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
